// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-latch sending side.
// Holds the default operand width, the stage tag width, the FSM state
// encoding, the use-mask bit positions and a helper that picks the next
// serial send state from a mask.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int STAGE_W    = 3;

  localparam int MASK_A = 0;
  localparam int MASK_B = 1;
  localparam int MASK_P = 2;

  // ST_SEND is only reached in the parallel build.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_B,
    ST_SEND_P,
    ST_ADVANCE,
    ST_SEND
  } state_t;

  // First send state whose mask bit is set, looking at bit positions
  // start..2 in order A, B, P. No remaining bit means ADVANCE.
  function automatic state_t first_send(input logic [2:0] mask,
                                        input logic [1:0] start);
    state_t nxt;
    nxt = ST_ADVANCE;
    if (start <= 2'd2 && mask[MASK_P]) nxt = ST_SEND_P;
    if (start <= 2'd1 && mask[MASK_B]) nxt = ST_SEND_B;
    if (start == 2'd0 && mask[MASK_A]) nxt = ST_SEND_A;
    return nxt;
  endfunction

endpackage

// File: rtl/alu_operand_driver_operand_fifo.sv
// operand_fifo: 2-entry synchronous FIFO with registered full/empty flags.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, wdata       write request (ignored while full) and payload
//   pop               read request (ignored while empty)
//   rdata             head entry, valid while empty is 0
//   full, empty       registered occupancy flags
// Storage is not reset; only pointers and flags are.
module operand_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wptr;
  logic             rptr;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)      count_nxt = count + 2'd1;
    else if (pop_ok && !push_ok) count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push_ok) wptr <= ~wptr;
      if (pop_ok)  rptr <= ~rptr;
      count <= count_nxt;
      full  <= (count_nxt == 2'd2);
      empty <= (count_nxt == 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/alu_operand_driver.sv
// alu_operand_driver: sending end of the ALU operand-latch interface.
// Accepts operand bundles {a, b, pass, mask} over valid/ready into a
// 2-entry buffer, then strobes each masked operand onto the ALU readd_*
// buses with a one-cycle readin_* pulse, and advances the stage tag.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   bundle_valid_i/bundle_ready_o  upstream handshake (ready registered)
//   op_a_i, op_b_i, op_pass_i      operands; use_mask_i selects which to send
//   readd_*_o, readin_*_o          ALU data buses and strobes
//   stage_o                        stage tag, 0..STAGE_MAX-1, wraps
//   busy_o                         buffer non-empty or FSM not idle
// Build option: define ALU_OPERAND_PARALLEL_EN to send all masked operands
// in one cycle (IDLE, SEND, ADVANCE) instead of one per cycle.
module alu_operand_driver
  import alu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int STAGE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bundle_valid_i,
  output logic              bundle_ready_o,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic [DATA_W-1:0] op_pass_i,
  input  logic [2:0]        use_mask_i,
  output logic [DATA_W-1:0] readd_a_o,
  output logic [DATA_W-1:0] readd_b_o,
  output logic [DATA_W-1:0] readd_pass_o,
  output logic              readin_a_o,
  output logic              readin_b_o,
  output logic              readin_pass_o,
  output logic [2:0]        stage_o,
  output logic              busy_o
);

  localparam int PAY_W = 3 * DATA_W + 3;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_MAX - 1);

  logic [PAY_W-1:0]  wdata;
  logic [PAY_W-1:0]  head;
  logic              full;
  logic              empty;
  logic              pop;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [DATA_W-1:0] head_p;
  logic [2:0]        head_mask;
  logic [2:0]        mask_q;
  state_t            state;

  assign wdata     = {use_mask_i, op_pass_i, op_b_i, op_a_i};
  assign head_a    = head[0 +: DATA_W];
  assign head_b    = head[DATA_W +: DATA_W];
  assign head_p    = head[2*DATA_W +: DATA_W];
  assign head_mask = head[3*DATA_W +: 3];

  // Head leaves the buffer on the ADVANCE edge.
  assign pop            = (state == ST_ADVANCE);
  assign bundle_ready_o = ~full;
  assign busy_o         = ~empty | (state != ST_IDLE);

  operand_fifo #(
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bundle_valid_i),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Send FSM: strobes are registered, so each pulse is visible in the cycle
  // after the corresponding SEND state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      mask_q        <= 3'b000;
      readd_a_o     <= '0;
      readd_b_o     <= '0;
      readd_pass_o  <= '0;
      readin_a_o    <= 1'b0;
      readin_b_o    <= 1'b0;
      readin_pass_o <= 1'b0;
      stage_o       <= '0;
    end else begin
      readin_a_o    <= 1'b0;
      readin_b_o    <= 1'b0;
      readin_pass_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            mask_q <= head_mask;
`ifdef ALU_OPERAND_PARALLEL_EN
            state  <= (head_mask != 3'b000) ? ST_SEND : ST_ADVANCE;
`else
            state  <= first_send(head_mask, 2'd0);
`endif
          end
        end
`ifdef ALU_OPERAND_PARALLEL_EN
        ST_SEND: begin
          if (mask_q[MASK_A]) begin
            readd_a_o  <= head_a;
            readin_a_o <= 1'b1;
          end
          if (mask_q[MASK_B]) begin
            readd_b_o  <= head_b;
            readin_b_o <= 1'b1;
          end
          if (mask_q[MASK_P]) begin
            readd_pass_o  <= head_p;
            readin_pass_o <= 1'b1;
          end
          state <= ST_ADVANCE;
        end
`else
        ST_SEND_A: begin
          readd_a_o  <= head_a;
          readin_a_o <= 1'b1;
          state      <= first_send(mask_q, 2'd1);
        end
        ST_SEND_B: begin
          readd_b_o  <= head_b;
          readin_b_o <= 1'b1;
          state      <= first_send(mask_q, 2'd2);
        end
        ST_SEND_P: begin
          readd_pass_o  <= head_p;
          readin_pass_o <= 1'b1;
          state         <= ST_ADVANCE;
        end
`endif
        ST_ADVANCE: begin
          stage_o <= (stage_o == STAGE_LAST) ? '0 : stage_o + STAGE_W'(1);
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_driver.sv
// Testbench for alu_operand_driver: scoreboard of expected strobe events
// and stage changes, filled when a bundle is accepted and drained by a
// negedge monitor. Honours ALU_OPERAND_PARALLEL_EN when defined.
module tb_alu_operand_driver;

  localparam int DATA_W    = 32;
  localparam int STAGE_MAX = 4;
`ifdef ALU_OPERAND_PARALLEL_EN
  localparam int BUNDLE_CYC = 3;
`else
  localparam int BUNDLE_CYC = 5;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              bundle_valid_i;
  logic              bundle_ready_o;
  logic [DATA_W-1:0] op_a_i, op_b_i, op_pass_i;
  logic [2:0]        use_mask_i;
  logic [DATA_W-1:0] readd_a_o, readd_b_o, readd_pass_o;
  logic              readin_a_o, readin_b_o, readin_pass_o;
  logic [2:0]        stage_o;
  logic              busy_o;

  always #5 clk = ~clk;

  alu_operand_driver #(
    .DATA_W    (DATA_W),
    .STAGE_MAX (STAGE_MAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bundle_valid_i (bundle_valid_i),
    .bundle_ready_o (bundle_ready_o),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .op_pass_i      (op_pass_i),
    .use_mask_i     (use_mask_i),
    .readd_a_o      (readd_a_o),
    .readd_b_o      (readd_b_o),
    .readd_pass_o   (readd_pass_o),
    .readin_a_o     (readin_a_o),
    .readin_b_o     (readin_b_o),
    .readin_pass_o  (readin_pass_o),
    .stage_o        (stage_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    logic [2:0]        s;
    logic [DATA_W-1:0] a, b, p;
    logic [2:0]        stage;
    int                cyc;
  } ev_t;

  typedef struct {
    logic [2:0] stage;
    int         cyc;
  } st_t;

  ev_t sq[$];
  st_t stq[$];

  int total = 0;
  int bad   = 0;
  int pcyc  = 0;
  int last_acc = 0;
  logic [2:0] stage_model = 3'd0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected events for a bundle accepted on posedge index n.
  task automatic push_expected(input logic [DATA_W-1:0] a, b, p,
                               input logic [2:0] m, input bit timed, input int n);
    ev_t e;
    st_t t;
    int  k;
    k = 3;
    e.a = a; e.b = b; e.p = p; e.stage = stage_model;
`ifdef ALU_OPERAND_PARALLEL_EN
    if (m != 3'b000) begin
      e.s   = m;
      e.cyc = timed ? n + k : -1;
      sq.push_back(e);
      k++;
    end
`else
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        e.s   = 3'b001 << i;
        e.cyc = timed ? n + k : -1;
        sq.push_back(e);
        k++;
      end
    end
`endif
    stage_model = (stage_model == 3'(STAGE_MAX - 1)) ? 3'd0 : stage_model + 3'd1;
    t.stage = stage_model;
    t.cyc   = timed ? n + k : -1;
    stq.push_back(t);
  endtask

  // Called at a negedge; returns at a negedge after the accept edge.
  task automatic drive(input logic [DATA_W-1:0] a, b, p, input logic [2:0] m,
                       input bit timed);
    bit acc;
    bit rdy;
    acc = 1'b0;
    bundle_valid_i = 1'b1;
    op_a_i = a; op_b_i = b; op_pass_i = p; use_mask_i = m;
    for (int i = 0; i < 100 && !acc; i++) begin
      rdy = bundle_ready_o;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        last_acc = pcyc;
        push_expected(a, b, p, m, timed, pcyc);
      end
      @(negedge clk);
    end
    bundle_valid_i = 1'b0;
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic flush_model();
    sq.delete();
    stq.delete();
    stage_model = 3'd0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    flush_model();
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (sq.size() == 0 && stq.size() == 0 && !busy_o) done = 1'b1;
      else @(negedge clk);
    end
    chk("drain", 64'(done), 64'd1);
  endtask

  // Monitor: strobes, held data and stage changes against the scoreboard.
  logic [DATA_W-1:0] last_a = '0, last_b = '0, last_p = '0;
  logic [2:0]        prev_stage = 3'd0;

  always @(negedge clk) begin : monitor
    logic [2:0] s;
    ev_t e;
    st_t t;
    if (reset) begin
      last_a = '0; last_b = '0; last_p = '0;
      prev_stage = 3'd0;
    end else begin
      s = {readin_pass_o, readin_b_o, readin_a_o};
      if (s != 3'b000) begin
        if (sq.size() == 0) begin
          chk("spurious_strobe", 64'(s), 64'd0);
        end else begin
          e = sq.pop_front();
          chk("strobe", 64'(s), 64'(e.s));
          if (e.cyc >= 0) chk("strobe_cycle", 64'(pcyc), 64'(e.cyc));
          chk("stage_in_send", 64'(stage_o), 64'(e.stage));
          if (e.s[0]) last_a = e.a;
          if (e.s[1]) last_b = e.b;
          if (e.s[2]) last_p = e.p;
        end
      end
      chk("readd_a", 64'(readd_a_o), 64'(last_a));
      chk("readd_b", 64'(readd_b_o), 64'(last_b));
      chk("readd_pass", 64'(readd_pass_o), 64'(last_p));
      if (stage_o != prev_stage) begin
        if (stq.size() == 0) begin
          chk("spurious_stage", 64'(stage_o), 64'(prev_stage));
        end else begin
          t = stq.pop_front();
          chk("stage", 64'(stage_o), 64'(t.stage));
          if (t.cyc >= 0) chk("stage_cycle", 64'(pcyc), 64'(t.cyc));
        end
        prev_stage = stage_o;
      end
    end
  end

  initial begin : main
    int  a1;
    bit  seen;
    reset = 1'b1;
    bundle_valid_i = 1'b0;
    op_a_i = '0; op_b_i = '0; op_pass_i = '0; use_mask_i = 3'b000;
    repeat (3) @(negedge clk);

    chk("rst_readin", 64'({readin_pass_o, readin_b_o, readin_a_o}), 64'd0);
    chk("rst_readd_a", 64'(readd_a_o), 64'd0);
    chk("rst_readd_b", 64'(readd_b_o), 64'd0);
    chk("rst_readd_pass", 64'(readd_pass_o), 64'd0);
    chk("rst_stage", 64'(stage_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(bundle_ready_o), 64'd1);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(bundle_ready_o), 64'd1);

    // Full-mask bundle, cycle-exact timing.
    drive(32'h11, 32'h22, 32'h33, 3'b111, 1'b1);
    chk("busy_after_accept", 64'(busy_o), 64'd1);
    wait_drain();
    chk("stage_after_one", 64'(stage_o), 64'd1);

    // Only B sent; A and pass buses stay at their reset value.
    do_reset();
    drive(32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 1'b1);
    wait_drain();
    chk("readd_a_untouched", 64'(readd_a_o), 64'd0);
    chk("readd_pass_untouched", 64'(readd_pass_o), 64'd0);
    chk("readd_b_sent", 64'(readd_b_o), 64'hDEADBEEF);

    // Three back-to-back bundles with valid held: buffer fills after two.
    drive($urandom, $urandom, $urandom, 3'b111, 1'b0);
    a1 = last_acc;
    drive($urandom, $urandom, $urandom, 3'b111, 1'b0);
    chk("ready_when_full", 64'(bundle_ready_o), 64'd0);
    chk("busy_when_full", 64'(busy_o), 64'd1);
    drive($urandom, $urandom, $urandom, 3'b111, 1'b0);
    chk("third_accept_cycle", 64'(last_acc), 64'(a1 + 1 + BUNDLE_CYC));
    wait_drain();

    // Empty masks only advance the stage, with wrap.
    do_reset();
    repeat (5) drive($urandom, $urandom, $urandom, 3'b000, 1'b0);
    wait_drain();
    chk("stage_after_five", 64'(stage_o), 64'd1);

    // Reset while B is being strobed; nothing resumes afterwards.
    drive($urandom, $urandom, $urandom, 3'b111, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = readin_b_o;
    end
    chk("saw_b_strobe", 64'(seen), 64'd1);
    #2;
    reset = 1'b1;
    flush_model();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_readin", 64'({readin_pass_o, readin_b_o, readin_a_o}), 64'd0);
    chk("midrst_stage", 64'(stage_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_ready", 64'(bundle_ready_o), 64'd1);
    #2;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_resume_busy", 64'(busy_o), 64'd0);

    // Mask A+pass, cycle-exact timing.
    drive(32'hA5A5A5A5, 32'h0BADF00D, 32'hC3C3C3C3, 3'b101, 1'b1);
    wait_drain();
    chk("readd_b_after_101", 64'(readd_b_o), 64'd0);

    // Random traffic, back-to-back.
    for (int i = 0; i < 10; i++)
      drive($urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_driver.md
Name: alu_operand_driver

Overview:
- Sending end of the ALU operand-latch interface. Accepts one decoded operand bundle per valid/ready handshake, holds it in a 2-entry buffer, and drives the ALU's readd_a/b/pass data buses and readin_a/b/pass strobes in order.
- Produces the 3-bit stage_o tag that the ALU samples on stage_i.
- Sits between decode/regfile read and the ALU.

Parameters:
- DATA_W, 32, operand width; must match the ALU readd_* buses.
- STAGE_MAX, 4, number of stage values; stage_o counts 0..STAGE_MAX-1; legal range 1..8.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- bundle_valid_i  input  1  upstream bundle valid
- bundle_ready_o  output  1  buffer can accept a bundle
- op_a_i  input  DATA_W  operand A
- op_b_i  input  DATA_W  operand B
- op_pass_i  input  DATA_W  pass-through value
- use_mask_i  input  3  bit0=A, bit1=B, bit2=pass; operands to send
- readd_a_o  output  DATA_W  to ALU readd_a_i
- readd_b_o  output  DATA_W  to ALU readd_b_i
- readd_pass_o  output  DATA_W  to ALU readd_pass_i
- readin_a_o  output  1  to ALU readin_a_i
- readin_b_o  output  1  to ALU readin_b_i
- readin_pass_o  output  1  to ALU readin_pass_i
- stage_o  output  3  to ALU stage_i
- busy_o  output  1  buffer non-empty or FSM not IDLE

Behaviour:
- Reset values, applied on the clk edge while reset=1:
  - all readd_* = 0, all readin_* = 0, stage_o = 0, busy_o = 0
  - buffer emptied; bundle_ready_o = 1 from the first cycle after reset.
- Reset mid-operation: the in-flight bundle is abandoned and no further strobes are issued. The ALU is reset on the same reset, so no partial state survives.
- Buffer:
  - 2-entry FIFO of {a, b, pass, mask}.
  - Accept when bundle_valid_i & bundle_ready_o.
  - bundle_ready_o = !full, registered, with no combinational path from any input.
  - Full: valid held high is not accepted and input is ignored until a pop.
  - Simultaneous push and pop while full: push is refused, because ready was already 0.
- FSM states: IDLE, SEND_A, SEND_B, SEND_P, ADVANCE.
  - IDLE: if buffer non-empty, latch the head mask and go to the first state whose mask bit is set, in order A, B, P. Mask 000 goes directly to ADVANCE.
  - SEND_x: for exactly one cycle, drive readd_x_o = head operand and readin_x_o = 1. Next state is the next set mask bit, else ADVANCE.
  - At most one readin_* strobe is high in any cycle.
  - Outside its SEND cycle, each readd_x_o holds its last value and its strobe is 0.
  - ADVANCE: pop the head. stage_o <= (stage_o == STAGE_MAX-1) ? 0 : stage_o+1. Next state is IDLE.
  - The stage wrap is mandatory.
- Latency: from acceptance of a bundle into an empty buffer with FSM in IDLE:
  - the first strobe appears 2 cycles after the accept edge;
  - a full-mask bundle occupies 5 cycles (IDLE, A, B, P, ADVANCE);
  - back-to-back bundles take 5 cycles each.
- stage_o is stable during all SEND cycles of a bundle and changes only at the ADVANCE edge.
- Width: operands pass unmodified; no sign or zero extension.

Optional Feature:
- Macro: ALU_OPERAND_PARALLEL_EN.
- Defined: SEND_A, SEND_B and SEND_P collapse into a single SEND state. All masked readin_* strobes assert together in one cycle, and a bundle takes 3 cycles (IDLE, SEND, ADVANCE). Mask 000 still skips SEND.
- Undefined: serial behaviour exactly as described above.

Decomposition:
- Shared package alu_pkg:
  - DATA_W default
  - stage width constant (3)
  - FSM state enum
  - mask bit index constants (MASK_A=0, MASK_B=1, MASK_P=2)
- One natural sub-module: operand_fifo, a 2-entry synchronous FIFO with registered full and empty flags, parameterised on payload width.

Test Plan:
- Reset, then one bundle a=0x11, b=0x22, pass=0x33, mask=111 -> readin_a at accept+2 with readd_a=0x11, then b=0x22 at +3, then pass=0x33 at +4; stage_o goes 0->1 at +5.
- Mask=010, b=0xDEADBEEF -> only readin_b pulses, for one cycle; readd_a/readd_pass stay 0; stage increments.
- Push 3 bundles back-to-back with valid held high -> bundle_ready_o drops after 2 accepts; the third is accepted after the first ADVANCE; no bundle is lost or duplicated.
- STAGE_MAX=4, 5 bundles with mask=000 -> stage_o sequence 1, 2, 3, 0, 1; no readin strobes.
- Assert reset during the SEND_B cycle -> the next cycle has all strobes 0, stage_o=0, busy_o=0, bundle_ready_o=1; the prior bundle is not resumed.
- With ALU_OPERAND_PARALLEL_EN and mask=101 -> readin_a and readin_pass are high in the same single cycle, readin_b stays 0, and the bundle completes in 3 cycles.
